// File: rtl/op_seq_pkg.sv
// Shared types and constants for the operand/operation sequencer.
// The optional DO_OP watchdog in op_sequencer is enabled with OP_SEQ_TIMEOUT_EN.
package op_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_VALIDATE   = 3'd3,
    ST_START_OP   = 3'd4,
    ST_DO_OP      = 3'd5,
    ST_READY      = 3'd6,
    ST_ERROR      = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_VAL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam int DEF_NUM_OPERANDS   = 2;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_MODE_W         = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int CNT_W              = 16;

endpackage

// File: rtl/op_seq_operand_bank.sv
// NUM_OPERANDS x DATA_W operand register file: one indexed write port,
// all entries visible on a flattened read bus (entry k at [k*DATA_W +: DATA_W]).
module op_seq_operand_bank
  import op_seq_pkg::*;
#(
  parameter int NUM_OPERANDS = DEF_NUM_OPERANDS,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int IDX_W        = $clog2(DEF_NUM_OPERANDS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  output logic [NUM_OPERANDS*DATA_W-1:0] rd_bus_o
);

  logic [DATA_W-1:0] mem_q [NUM_OPERANDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPERANDS; k++) mem_q[k] <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (wr_idx_i == IDX_W'(k)) mem_q[k] <= wr_data_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_rd
    assign rd_bus_o[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/op_sequencer.sv
// Control sequencer: collects NUM_OPERANDS operands, latches a mode on start,
// validates, pulses op_en and waits for done. OP_SEQ_TIMEOUT_EN adds a DO_OP watchdog.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int NUM_OPERANDS   = DEF_NUM_OPERANDS,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MODE_W         = DEF_MODE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [DATA_W-1:0]                 data_in,
  input  logic                              start,
  input  logic [MODE_W-1:0]                 mode_in,
  input  logic                              error,
  input  logic                              done,
  output logic [NUM_OPERANDS*DATA_W-1:0]    operands_out,
  output logic [MODE_W-1:0]                 mode_out,
  output logic [$clog2(NUM_OPERANDS):0]     load_idx,
  output logic                              val,
  output logic                              op_en,
  output logic                              busy,
  output logic                              ready,
  output logic                              error_out,
  output logic [1:0]                        err_code
);

  localparam int IDX_W = $clog2(NUM_OPERANDS) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPERANDS);

  if (NUM_OPERANDS < 1 || NUM_OPERANDS > 16) begin : g_bad_num_operands
    $error("op_sequencer: NUM_OPERANDS must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("op_sequencer: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [1:0]          err_q, err_d;

  logic                capture_st;
  logic                restart_st;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    idx_inc;

`ifdef OP_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign capture_st = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                      (state_q == ST_READY) || (state_q == ST_ERROR);
  assign restart_st = (state_q == ST_READY) || (state_q == ST_ERROR);
  assign wr_en      = load && capture_st;
  // A new batch after READY/ERROR always starts over at operand 0.
  assign wr_idx     = restart_st ? '0 : idx_q;
  assign idx_inc    = restart_st ? IDX_W'(1)
                    : ((idx_q < IDX_LAST) ? idx_q + IDX_W'(1) : idx_q);

  op_seq_operand_bank #(
    .NUM_OPERANDS (NUM_OPERANDS),
    .DATA_W       (DATA_W),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (data_in),
    .rd_bus_o  (operands_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      mode_q <= '0;
      err_q  <= ERR_NONE;
`ifdef OP_SEQ_TIMEOUT_EN
      cnt_q  <= '0;
`endif
    end else begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
      err_q  <= err_d;
`ifdef OP_SEQ_TIMEOUT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    err_d   = err_q;
`ifdef OP_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (wr_en) begin
      idx_d = idx_inc;
      if (restart_st) err_d = ERR_NONE;
    end
    case (state_q)
      ST_IDLE, ST_LOAD, ST_READY, ST_ERROR: begin
        if (load) state_d = (idx_inc == IDX_LAST) ? ST_WAIT_START : ST_LOAD;
      end
      ST_WAIT_START: begin
        if (start) begin
          mode_d  = mode_in;
          state_d = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        if (error) begin
          err_d   = ERR_VAL;
          state_d = ST_ERROR;
        end else begin
          state_d = ST_START_OP;
        end
      end
      ST_START_OP: begin
        state_d = ST_DO_OP;
`ifdef OP_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_DO_OP: begin
`ifdef OP_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = ST_READY;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TMO;
          state_d = ST_ERROR;
        end
`else
        if (done) state_d = ST_READY;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Status outputs are a pure decode of the registered state.
  always_comb begin
    val       = (state_q == ST_VALIDATE);
    op_en     = (state_q == ST_START_OP);
    busy      = (state_q == ST_VALIDATE) || (state_q == ST_START_OP) ||
                (state_q == ST_DO_OP);
    ready     = (state_q == ST_READY);
    error_out = (state_q == ST_ERROR);
  end

  assign mode_out = mode_q;
  assign load_idx = idx_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Randomised bench for op_sequencer (2x8-bit build plus a single-operand build),
// checked against a transaction-level model of the operand/mode/error bookkeeping.
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, start, error, done;
  logic [7:0]  data_in;
  logic [1:0]  mode_in;
  logic [15:0] operands_out;
  logic [1:0]  mode_out;
  logic [1:0]  load_idx;
  logic        val, op_en, busy, ready, error_out;
  logic [1:0]  err_code;

  logic        load1, start1, done1;
  logic [7:0]  data1;
  logic [7:0]  ops1;
  logic [1:0]  mode_out1;
  logic [0:0]  idx1;
  logic        val1, op_en1, busy1, ready1, error_out1;
  logic [1:0]  err_code1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_ops [2];
  logic [1:0] exp_mode;
  logic [1:0] exp_err;

  always #5 clk = ~clk;

  op_sequencer #(.NUM_OPERANDS(2), .DATA_W(8), .MODE_W(2), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .start(start),
    .mode_in(mode_in), .error(error), .done(done), .operands_out(operands_out),
    .mode_out(mode_out), .load_idx(load_idx), .val(val), .op_en(op_en),
    .busy(busy), .ready(ready), .error_out(error_out), .err_code(err_code)
  );

  op_sequencer #(.NUM_OPERANDS(1), .DATA_W(8), .MODE_W(2), .TIMEOUT_CYCLES(8)) u_dut1 (
    .clk(clk), .rst(rst), .load(load1), .data_in(data1), .start(start1),
    .mode_in(2'b01), .error(1'b0), .done(done1), .operands_out(ops1),
    .mode_out(mode_out1), .load_idx(idx1), .val(val1), .op_en(op_en1),
    .busy(busy1), .ready(ready1), .error_out(error_out1), .err_code(err_code1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_bus();
    return {exp_ops[1], exp_ops[0]};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ops"},  32'(operands_out), 32'h0);
    check_eq({tag, "_mode"}, 32'(mode_out), 32'h0);
    check_eq({tag, "_idx"},  32'(load_idx), 32'h0);
    check_eq({tag, "_flags"}, 32'({val, op_en, busy, ready, error_out}), 32'h0);
    check_eq({tag, "_err"},  32'(err_code), 32'h0);
  endtask

  // One operand capture; pos is where the model expects it to land.
  task automatic load_one(input int pos, input int exp_idx, input logic [7:0] v, input bit with_start);
    load = 1'b1; data_in = v; start = with_start;
    tick();
    load = 1'b0; start = 1'b0;
    exp_ops[pos] = v;
    if (pos == 0) exp_err = 2'b00;
    check_eq("load_idx", 32'(load_idx), 32'(exp_idx));
    check_eq("load_ops", 32'(operands_out), 32'(exp_bus()));
    check_eq("load_err", 32'(err_code), 32'(exp_err));
    check_eq("load_val", 32'({val, busy}), 32'h0);
  endtask

  // From WAIT_START: start, validate, op_en, then done after dly DO_OP cycles (dly<0: never).
  task automatic exec_op(input logic [1:0] m, input bit err, input int dly, input bit noise);
    if (noise) begin
      load = 1'b1; data_in = 8'($urandom); done = 1'b1;
      tick();
      load = 1'b0; done = 1'b0;
      check_eq("ws_idx", 32'(load_idx), 32'd2);
      check_eq("ws_ops", 32'(operands_out), 32'(exp_bus()));
      check_eq("ws_flags", 32'({val, busy, ready}), 32'h0);
    end
    start = 1'b1; mode_in = m;
    tick();
    start = 1'b0; mode_in = ~m; exp_mode = m;
    check_eq("val", 32'({val, op_en, busy}), 32'b101);
    check_eq("mode", 32'(mode_out), 32'(exp_mode));
    error = err;
    tick();
    error = 1'b0;
    if (err) begin
      exp_err = 2'b01;
      check_eq("vfail_flags", 32'({error_out, op_en, busy}), 32'b100);
      check_eq("vfail_code", 32'(err_code), 32'(exp_err));
      return;
    end
    check_eq("op_en", 32'({op_en, val, busy}), 32'b101);
    tick();
    check_eq("do_op", 32'({op_en, busy, ready}), 32'b010);
    if (dly < 0) begin
`ifdef OP_SEQ_TIMEOUT_EN
      for (int k = 0; k < 7; k++) begin
        tick();
        check_eq("tmo_wait", 32'({busy, error_out}), 32'b10);
      end
      tick();
      exp_err = 2'b10;
      check_eq("tmo_flags", 32'({error_out, busy, ready}), 32'b100);
      check_eq("tmo_code", 32'(err_code), 32'(exp_err));
      return;
`else
      dly = 20;
`endif
    end
    for (int k = 0; k < dly; k++) begin
      tick();
      check_eq("do_wait", 32'({busy, ready, error_out}), 32'b100);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("ready", 32'({ready, busy, error_out}), 32'b100);
    check_eq("rdy_err", 32'(err_code), 32'(exp_err));
    check_eq("rdy_mode", 32'(mode_out), 32'(exp_mode));
    check_eq("rdy_ops", 32'(operands_out), 32'(exp_bus()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 0; start = 0; error = 0; done = 0; data_in = 0; mode_in = 0;
    load1 = 0; start1 = 0; done1 = 0; data1 = 0;
    exp_ops[0] = 0; exp_ops[1] = 0; exp_mode = 0; exp_err = 0;
    tick(); tick();
    check_all_zero("rst");
    rst = 1'b0;

    // Reset while waiting in DO_OP
    load_one(0, 1, 8'h12, 1'b0);
    load_one(1, 2, 8'h34, 1'b0);
    start = 1'b1; mode_in = 2'b11;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops[0] = 0; exp_ops[1] = 0; exp_mode = 0; exp_err = 0;
    check_all_zero("rst_doop");

    // Directed normal operation
    load_one(0, 1, 8'h12, 1'b0);
    load_one(1, 2, 8'h34, 1'b0);
    exec_op(2'b10, 1'b0, 1, 1'b0);
    check_eq("norm_bus", 32'(operands_out), 32'h3412);

    // Validate fail, then restart capture at operand 0
    load_one(0, 1, 8'h56, 1'b0);
    load_one(1, 2, 8'h78, 1'b0);
    exec_op(2'b01, 1'b1, 0, 1'b0);
    load_one(0, 1, 8'hAA, 1'b0);
    check_eq("after_err_bus", 32'(operands_out), 32'h78AA);
    load_one(1, 2, 8'h9C, 1'b0);
    exec_op(2'b00, 1'b0, 0, 1'b0);

    // Ignored inputs: start in LOAD, load/done in WAIT_START
    load_one(0, 1, 8'h3C, 1'b0);
    load_one(1, 2, 8'hC3, 1'b1);
    exec_op(2'b11, 1'b0, 2, 1'b1);

    // Timeout boundary (done on last allowed DO_OP cycle), then no done at all
    load_one(0, 1, 8'h01, 1'b0);
    load_one(1, 2, 8'h02, 1'b0);
    exec_op(2'b10, 1'b0, 7, 1'b0);
    load_one(0, 1, 8'h03, 1'b0);
    load_one(1, 2, 8'h04, 1'b0);
    exec_op(2'b01, 1'b0, -1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      load_one(0, 1, 8'($urandom), 1'b0);
      load_one(1, 2, 8'($urandom), ($urandom_range(0, 1) == 1));
      exec_op(2'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
              ($urandom_range(0, 1) == 1));
    end

    // Single-operand build
    load1 = 1'b1; data1 = 8'h5A;
    tick();
    check_eq("s1_idx", 32'(idx1), 32'd1);
    check_eq("s1_ops", 32'(ops1), 32'h5A);
    data1 = 8'h77;
    tick();
    load1 = 1'b0;
    check_eq("s1_sat_idx", 32'(idx1), 32'd1);
    check_eq("s1_sat_ops", 32'(ops1), 32'h5A);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check_eq("s1_val", 32'({val1, busy1}), 32'b11);
    tick();
    check_eq("s1_op_en", 32'(op_en1), 32'd1);
    tick();
    done1 = 1'b1;
    tick(); done1 = 1'b0;
    check_eq("s1_ready", 32'({ready1, busy1}), 32'b10);
    check_eq("s1_mode", 32'(mode_out1), 32'd1);
    load1 = 1'b1; data1 = 8'hC3;
    tick(); load1 = 1'b0;
    check_eq("s1_reload", 32'({idx1, ops1}), 32'h1C3);
    check_eq("s1_reload_flags", 32'({ready1, error_out1, err_code1}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Parametrised control sequencer for the arithmetic datapath.
- Collects NUM_OPERANDS operands through a load strobe and captures a mode word on start.
- Runs one validate cycle, then pulses the operation enable and waits for done, with an optional watchdog.
- Sits between the user/bus side and the multi-operand execution unit; replaces the fixed two-operand controller.

Parameters:
- NUM_OPERANDS, 2, operands captured per operation; legal range 1..16.
- DATA_W, 16, width of each operand.
- MODE_W, 2, width of the operation mode word.
- TIMEOUT_CYCLES, 1024, maximum DO_OP cycles before timeout; legal range 2..65535; used only with OP_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  operand strobe; each high cycle in a capturing state captures one operand.
- data_in  in  DATA_W  operand data, sampled with load.
- start  in  1  request to start the operation.
- mode_in  in  MODE_W  operation mode, sampled on the cycle start is accepted.
- error  in  1  operand-check result from the datapath; sampled only in VALIDATE.
- done  in  1  completion from the execution unit; sampled only in DO_OP.
- operands_out  out  NUM_OPERANDS*DATA_W  captured operands; operand k occupies bits [k*DATA_W +: DATA_W].
- mode_out  out  MODE_W  captured mode.
- load_idx  out  $clog2(NUM_OPERANDS)+1  number of operands captured so far.
- val  out  1  high in VALIDATE.
- op_en  out  1  single-cycle pulse in START_OP.
- busy  out  1  high in VALIDATE, START_OP and DO_OP.
- ready  out  1  high in READY.
- error_out  out  1  high in ERROR.
- err_code  out  2  00 none, 01 validate fail, 10 timeout; held until the next load.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, load_idx=0, all operands=0, mode_out=0.
  - val, op_en, busy, ready, error_out=0; err_code=00.
  - Reset wins over every other input in any state, including mid-DO_OP.
- All outputs are registered and are a pure decode of the current state register; no combinational input-to-output paths.
- Operand capture:
  - In IDLE, LOAD, READY or ERROR, load=1 writes data_in to operand[load_idx] and increments load_idx.
  - From READY or ERROR, the capture goes to operand 0; load_idx becomes 1 and err_code clears to 00.
  - Operands not yet rewritten keep their old values.
- State transitions:
  - IDLE: load goes to LOAD, or to WAIT_START if NUM_OPERANDS=1.
  - LOAD: go to WAIT_START on the cycle the last operand is captured (load_idx reaches NUM_OPERANDS); start is ignored here.
  - WAIT_START: start=1 latches mode_in and goes to VALIDATE; load is ignored (start/load priority is moot here).
  - VALIDATE (1 cycle): error=1 goes to ERROR with err_code=01; otherwise goes to START_OP.
  - START_OP (1 cycle): op_en=1, then DO_OP.
  - DO_OP: done=1 goes to READY; done is ignored in every other state.
  - READY and ERROR: hold until load, which captures operand 0 and goes to LOAD (or WAIT_START if NUM_OPERANDS=1).
- Latency:
  - start accepted at edge N gives val high in cycle N+1 and op_en high in cycle N+2.
  - done sampled at edge M gives ready high in cycle M+1.
- load_idx saturates at NUM_OPERANDS; it never wraps.
- The state encoding is illegal-safe: any unreachable code returns to IDLE on the next edge.

Optional Feature:
- Macro: OP_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter clears on entry to DO_OP and increments each DO_OP cycle.
  - If done is still 0 when the counter reaches TIMEOUT_CYCLES-1, the next state is ERROR with err_code=10.
  - done=1 on that same cycle wins and goes to READY.
- Undefined: no counter; DO_OP waits indefinitely; err_code=10 never occurs.

Decomposition:
- Package op_seq_pkg:
  - state enum type.
  - err_code localparams ERR_NONE, ERR_VAL, ERR_TMO.
  - Default width constants.
- Sub-module op_seq_operand_bank: the NUM_OPERANDS x DATA_W register file with indexed write and flattened read bus.
- The FSM, counters and output decode stay in op_sequencer.

Test Plan:
- Reset mid-DO_OP: with NUM_OPERANDS=2, DATA_W=8, load 0x12 then 0x34, start, hold done=0, assert rst in DO_OP -> next cycle every output is 0 and state=IDLE.
- Normal operation: load 0x12 then 0x34, start with mode_in=2'b10, done three cycles after op_en -> operands_out=0x3412, mode_out=10, val one cycle after start, op_en one cycle after val, ready one cycle after done.
- Validate fail: error=1 during VALIDATE -> error_out=1, err_code=01, no op_en pulse; a following load 0xAA -> operand0=0xAA, load_idx=1, err_code=00.
- Ignored inputs: start during LOAD, and load during WAIT_START -> both ignored; done pulsed in WAIT_START -> no effect.
- Timeout (OP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8), done held 0 -> ERROR with err_code=10 exactly 8 cycles after DO_OP entry.
- Timeout boundary (same configuration): done=1 on the 8th DO_OP cycle -> READY, err_code=00.
- Single-operand build (NUM_OPERANDS=1): one load goes directly to WAIT_START; load_idx=1 and saturates under further loads.
